// File: rtl/pico_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pico_arb_pkg
// Shared types and constants for the two-master picorv32 memory arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, BUSY0, BUSY1)
//   mem_req_t     : latched downstream request {addr, wdata, wstrb}
//   TIMEOUT_RDATA : read data returned to a master whose access timed out
// The REQ_* widths are the widest request the arbiter can latch. A top-level
// ADDR_W/DATA_W larger than these is not supported.
// ---------------------------------------------------------------------------
package pico_arb_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_STRB_W = REQ_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam logic [REQ_DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/pico_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// pico_mem_arbiter_if
// picorv32-style native memory port bundle.
//   valid : request (driven by the requester)
//   ready : completion pulse (driven by the responder)
//   addr  : request address
//   wdata : write data
//   wstrb : byte strobes, 0 means read
//   rdata : read data, valid together with ready
// Modports:
//   master : requester side (drives valid/addr/wdata/wstrb)
//   slave  : responder side (drives ready/rdata)
// ---------------------------------------------------------------------------
interface pico_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                valid;
  logic                ready;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/pico_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// pico_rr_pick
// Two-way round-robin selector.
//   i_valid0/1   : pending requests
//   i_last_grant : master served by the previous transaction
//   o_any        : at least one request pending
//   o_pick       : selected master (meaningful only when o_any is high)
// On a tie the master that was not served last wins; otherwise the single
// requester wins.
// ---------------------------------------------------------------------------
module pico_rr_pick (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_any,
  output logic o_pick
);

  always_comb begin
    o_any  = i_valid0 | i_valid1;
    o_pick = i_valid1;
    if (i_valid0 && i_valid1) begin
      o_pick = ~i_last_grant;
    end
  end

endmodule

// File: rtl/pico_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pico_mem_arbiter
// Shares one picorv32 native memory port between master m0 (core) and m1
// (loader/DMA) with round-robin fairness, one transaction per grant.
//   clock, reset : system clock, synchronous active-high reset
//   m0, m1       : master ports (slave modport of pico_mem_arbiter_if)
//   mem          : downstream memory port (master modport)
//   grant_id     : master owning the current / last transaction
//   busy         : high while a transaction is outstanding
//   timeout_err  : sticky watchdog flag (only with PICO_ARB_TIMEOUT_EN)
// Optional build macro PICO_ARB_TIMEOUT_EN adds a watchdog that completes a
// stuck access after TIMEOUT_CYC busy cycles with rdata 32'hDEAD_BEEF.
// Timing: request sampled in IDLE -> mem.valid the next cycle; mem.ready
// completes the access combinationally to the owner and returns to IDLE, so
// there is always one idle cycle between transactions.
// ---------------------------------------------------------------------------
module pico_mem_arbiter
  import pico_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  pico_mem_arbiter_if.slave        m0,
  pico_mem_arbiter_if.slave        m1,
  pico_mem_arbiter_if.master       mem,
  output logic                     grant_id,
  output logic                     busy
`ifdef PICO_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic                r_last_grant;
  logic                r_grant_id;
  logic                r_mem_valid;
  mem_req_t            r_req;
  mem_req_t            w_sel_req;
  logic                w_any;
  logic                w_pick;
  logic                w_start;
  logic                w_done;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_rdata_sel;

  pico_rr_pick u_pick (
    .i_valid0     (m0.valid),
    .i_valid1     (m1.valid),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_pick       (w_pick)
  );

  // Request of the master chosen by the round-robin pick.
  always_comb begin
    w_sel_req = '0;
    if (w_pick) begin
      w_sel_req.addr  = REQ_ADDR_W'(m1.addr);
      w_sel_req.wdata = REQ_DATA_W'(m1.wdata);
      w_sel_req.wstrb = REQ_STRB_W'(m1.wstrb);
    end else begin
      w_sel_req.addr  = REQ_ADDR_W'(m0.addr);
      w_sel_req.wdata = REQ_DATA_W'(m0.wdata);
      w_sel_req.wstrb = REQ_STRB_W'(m0.wstrb);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_start = 1'b1;
          w_next  = w_pick ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (mem.ready || w_timeout) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_req        <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_req       <= w_sel_req;
        r_mem_valid <= 1'b1;
        r_grant_id  <= w_pick;
      end else if (w_done) begin
        r_mem_valid  <= 1'b0;
        r_last_grant <= (r_state == BUSY1);
      end
    end
  end

`ifdef PICO_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_wd_cnt;
  logic        r_timeout_err;

  // Fires in the TIMEOUT_CYC-th busy cycle that has no mem.ready.
  assign w_timeout = (r_state != IDLE) && !mem.ready && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_wd_cnt <= '0;
      end else if ((r_state != IDLE) && !mem.ready) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_rdata_sel = w_timeout ? DATA_W'(TIMEOUT_RDATA) : mem.rdata;

  assign m0.ready = (r_state == BUSY0) && w_done;
  assign m1.ready = (r_state == BUSY1) && w_done;
  assign m0.rdata = (r_state == BUSY0) ? w_rdata_sel : '0;
  assign m1.rdata = (r_state == BUSY1) ? w_rdata_sel : '0;

  assign mem.valid = r_mem_valid;
  assign mem.addr  = r_req.addr[ADDR_W-1:0];
  assign mem.wdata = r_req.wdata[DATA_W-1:0];
  assign mem.wstrb = r_req.wstrb[DATA_W/8-1:0];

  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);

endmodule
